// File: rtl/jtag_gpio_top.sv
// jtag_gpio_top: IEEE 1149.1 TAP that drives three LEDs through GPIO registers.
// The TAP offers IDCODE, BYPASS, GPIO_CONFIG (output enable) and GPIO_DATA.
// GPIO state lives in the tck domain. It passes through SYNC_STAGES clk flops
// before it reaches led0..led2.
// Build option: define JTAG_GPIO_BUTTON_EN so that opcode 4'h4 selects a 1-bit
// DR that captures the synchronized, inverted button_ input. When the macro is
// undefined, 4'h4 behaves as BYPASS.
module jtag_gpio_top #(
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic trst_,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic led0,
  output logic led1,
  output logic led2,
  input  logic button_
);

  localparam int IR_LENGTH = 4;

  localparam logic [IR_LENGTH-1:0] OP_IDCODE = 4'h1;
  localparam logic [IR_LENGTH-1:0] OP_CONFIG = 4'h2;
  localparam logic [IR_LENGTH-1:0] OP_DATA   = 4'h3;
  localparam logic [IR_LENGTH-1:0] OP_BUTTON = 4'h4;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  typedef enum logic [2:0] {
    DR_BYPASS, DR_IDCODE, DR_CONFIG, DR_DATA, DR_BUTTON
  } dr_sel_t;

  tap_state_t               state, state_next;
  logic                     in_tlr, capture_dr, shift_dr, update_dr;
  logic                     capture_ir, shift_ir, update_ir;
  logic [IR_LENGTH-1:0]     ir, ir_shift;
  dr_sel_t                  dr_sel;
  logic [31:0]              dr_shift;
  logic [2:0]               gpio_cfg, gpio_data;
  logic [1:0]               btn_sync;
  logic [SYNC_STAGES-1:0][2:0] led_sync;

  // TAP state register, forced to Test-Logic-Reset by trst_.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // pre-edge values regardless of block ordering.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) state <= TLR;
    else       state <= state_next;
  end

  // 1149.1 TMS transition table.
  always_comb begin
    state_next = state;
    unique case (state)
      TLR:      state_next = tms ? TLR      : RTI;
      RTI:      state_next = tms ? SEL_DR   : RTI;
      SEL_DR:   state_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   state_next = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_next = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_next = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_next = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_next = tms ? SEL_DR   : RTI;
      SEL_IR:   state_next = tms ? TLR      : CAP_IR;
      CAP_IR:   state_next = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_next = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_next = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_next = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_next = tms ? SEL_DR   : RTI;
      default:  state_next = TLR;
    endcase
  end

  // State decode strobes used by the IR/DR datapaths.
  always_comb begin
    in_tlr     = (state == TLR);
    capture_dr = (state == CAP_DR);
    shift_dr   = (state == SHIFT_DR);
    update_dr  = (state == UPD_DR);
    capture_ir = (state == CAP_IR);
    shift_ir   = (state == SHIFT_IR);
    update_ir  = (state == UPD_IR);
  end

  // Instruction register: capture pattern, LSB-first shift, update on Update-IR.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) begin
      ir       <= OP_IDCODE;
      ir_shift <= '0;
    end else begin
      if (in_tlr)         ir <= OP_IDCODE;
      else if (update_ir) ir <= ir_shift;
      if (capture_ir)     ir_shift <= 4'b0101;
      else if (shift_ir)  ir_shift <= {tdi, ir_shift[IR_LENGTH-1:1]};
    end
  end

  // Opcode to data-register selection; unknown opcodes fall back to BYPASS.
  // NOTE: the default assignment before the case keeps this block latch-free.
  always_comb begin
    dr_sel = DR_BYPASS;
    case (ir)
      OP_IDCODE: dr_sel = DR_IDCODE;
      OP_CONFIG: dr_sel = DR_CONFIG;
      OP_DATA:   dr_sel = DR_DATA;
`ifdef JTAG_GPIO_BUTTON_EN
      OP_BUTTON: dr_sel = DR_BUTTON;
`else
      OP_BUTTON: dr_sel = DR_BYPASS;
`endif
      default:   dr_sel = DR_BYPASS;
    endcase
  end

  // Button synchronizer into the tck domain; stores the pressed level.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) btn_sync <= '0;
    else       btn_sync <= {btn_sync[0], ~button_};
  end

  // Shared DR shift register; tdi enters the MSB of the selected length.
  // NOTE: the shift register is reset too, so tdo never exposes X after trst_.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) begin
      dr_shift <= '0;
    end else if (capture_dr) begin
      case (dr_sel)
        DR_IDCODE: dr_shift <= IDCODE_VALUE;
        DR_CONFIG: dr_shift <= {29'b0, gpio_cfg};
        DR_DATA:   dr_shift <= {29'b0, gpio_data};
        DR_BUTTON: dr_shift <= {31'b0, btn_sync[1]};
        default:   dr_shift <= '0;
      endcase
    end else if (shift_dr) begin
      case (dr_sel)
        DR_IDCODE:          dr_shift      <= {tdi, dr_shift[31:1]};
        DR_CONFIG, DR_DATA: dr_shift[2:0] <= {tdi, dr_shift[2:1]};
        default:            dr_shift[0]   <= tdi;
      endcase
    end
  end

  // GPIO registers, written on Update-DR; only trst_ clears them.
  always_ff @(posedge tck or posedge trst_) begin
    if (trst_) begin
      gpio_cfg  <= '0;
      gpio_data <= '0;
    end else if (update_dr) begin
      if (dr_sel == DR_CONFIG) gpio_cfg  <= dr_shift[2:0];
      if (dr_sel == DR_DATA)   gpio_data <= dr_shift[2:0];
    end
  end

  // tdo launched on the falling edge from the active shift register's bit0.
  always_ff @(negedge tck or posedge trst_) begin
    if (trst_)         tdo <= 1'b0;
    else if (shift_ir) tdo <= ir_shift[0];
    else if (shift_dr) tdo <= dr_shift[0];
    else               tdo <= 1'b0;
  end

  // clk-domain synchronizer for the gated LED levels.
  always_ff @(posedge clk or posedge trst_) begin
    if (trst_) begin
      led_sync <= '0;
    end else begin
      led_sync[0] <= gpio_cfg & gpio_data;
      for (int i = 1; i < SYNC_STAGES; i++) led_sync[i] <= led_sync[i-1];
    end
  end

  assign {led2, led1, led0} = led_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_jtag_gpio_top.sv
// tb_jtag_gpio_top: table-driven IR/DR scans with a scoreboard of expected
// captured words, plus hand-written reset, TMS-reset and abort sequences.
module tb_jtag_gpio_top;

  localparam logic [31:0] IDCODE = 32'h149511C3;
  localparam int          SYNC   = 2;
`ifdef JTAG_GPIO_BUTTON_EN
  localparam logic [31:0] BTN_EXP = 32'h1;
`else
  localparam logic [31:0] BTN_EXP = 32'h0;
`endif

  logic clk = 1'b0, tck = 1'b0;
  logic trst_ = 1'b1, tms = 1'b1, tdi = 1'b0, button_ = 1'b0;
  logic tdo, led0, led1, led2;

  int checks = 0, failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [3:0]  ir;
    int          len;
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  leds;
    int          pause_at;
  } vec_t;

  vec_t vecs[16];

  jtag_gpio_top dut (
    .clk(clk), .trst_(trst_), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
    .led0(led0), .led1(led1), .led2(led2), .button_(button_)
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #20 tck = ~tck;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic m, input logic d, output logic o);
    @(negedge tck);
    tms = m;
    tdi = d;
    @(posedge tck);
    #1;
    o = tdo;
  endtask

  // Full scan starting and ending in Run-Test-Idle, optional pause after bit pause_at.
  task automatic scan(input logic is_ir, input int len, input logic [31:0] din,
                      input int pause_at, output logic [31:0] dout);
    logic o;
    logic last;
    dout = '0;
    step(1'b1, 1'b0, o);
    if (is_ir) step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < len; i++) begin
      last = (i == len - 1);
      step(last || (i == pause_at), din[i], o);
      dout[i] = o;
      if (!last && i == pause_at) begin
        step(1'b0, 1'b0, o);
        step(1'b0, 1'b0, o);
        step(1'b1, 1'b0, o);
        step(1'b0, 1'b0, o);
      end
    end
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  task automatic scan_check(input string name, input logic is_ir, input int len,
                            input logic [31:0] din, input int pause_at);
    logic [31:0] got;
    logic [31:0] exp;
    scan(is_ir, len, din, pause_at, got);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check(name, got, exp);
    end
  endtask

  task automatic check_leds(input string name, input logic [2:0] exp);
    int n = 0;
    while ({led2, led1, led0} !== exp && n < SYNC + 1) begin
      @(negedge clk);
      n++;
    end
    check(name, {29'b0, led2, led1, led0}, {29'b0, exp});
  endtask

  task automatic tms_reset();
    logic o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  initial begin
    logic o;
    //            ir     len din       dout     leds    pause
    vecs[0]  = '{4'hF, 8, 32'hA5, 32'h4A,    3'b000, -1};
    vecs[1]  = '{4'hA, 8, 32'hA5, 32'h4A,    3'b000, -1};
    vecs[2]  = '{4'h1, 32, 32'h0, IDCODE,    3'b000, -1};
    vecs[3]  = '{4'h2, 3, 32'h7,  32'h0,     3'b000, -1};
    vecs[4]  = '{4'h3, 3, 32'h7,  32'h0,     3'b111, -1};
    vecs[5]  = '{4'h3, 3, 32'h0,  32'h7,     3'b000, -1};
    for (int k = 1; k <= 7; k++)
      vecs[5+k] = '{4'h3, 3, 32'(k), 32'(k-1), 3'(k), -1};
    vecs[13] = '{4'h2, 3, 32'h1,  32'h7,     3'b001, -1};
    vecs[14] = '{4'h2, 3, 32'h6,  32'h1,     3'b110, 0};
    vecs[15] = '{4'h4, 1, 32'h0,  BTN_EXP,   3'b110, -1};

    // Reset state while trst_ is held.
    #30;
    check("reset_tdo", {31'b0, tdo}, 32'd0);
    check("reset_leds", {29'b0, led2, led1, led0}, 32'd0);
    @(negedge tck);
    trst_ = 1'b0;

    // IDCODE selected without any IR load.
    tms_reset();
    sb_q.push_back(IDCODE);
    scan_check("idcode_default", 1'b0, 32, 32'h0, -1);

    // Table-driven IR + DR scans.
    for (int v = 0; v < 16; v++) begin
      sb_q.push_back(32'h5);
      sb_q.push_back(vecs[v].dout);
      scan_check($sformatf("v%0d_ir_capture", v), 1'b1, 4, {28'b0, vecs[v].ir}, -1);
      scan_check($sformatf("v%0d_dr_out", v), 1'b0, vecs[v].len, vecs[v].din, vecs[v].pause_at);
      check_leds($sformatf("v%0d_leds", v), vecs[v].leds);
    end

    // TMS reset returns IR to IDCODE but keeps GPIO state.
    tms_reset();
    check_leds("tms_reset_leds_kept", 3'b110);
    sb_q.push_back(IDCODE);
    scan_check("tms_reset_idcode", 1'b0, 32, 32'h0, -1);

    // trst_ mid-scan aborts and clears everything.
    sb_q.push_back(32'h5);
    scan_check("abort_ir_capture", 1'b1, 4, 32'h3, -1);
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b1, o);
    step(1'b0, 1'b1, o);
    #7;
    trst_ = 1'b1;
    #50;
    check("abort_tdo", {31'b0, tdo}, 32'd0);
    check("abort_leds", {29'b0, led2, led1, led0}, 32'd0);
    @(negedge tck);
    trst_ = 1'b0;
    step(1'b0, 1'b0, o);
    sb_q.push_back(IDCODE);
    scan_check("abort_idcode", 1'b0, 32, 32'h0, -1);
    sb_q.push_back(32'h5);
    sb_q.push_back(32'h0);
    scan_check("abort_ir2", 1'b1, 4, 32'h3, -1);
    scan_check("abort_data_cleared", 1'b0, 3, 32'h0, -1);
    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
